// File: rtl/mpu_issue.sv
// mpu_issue: descriptor FIFO plus a cycle-exact mirror of the mpu_ctrl
// IDLE/MMAC/MMUL sequencer, driving convctl_mpu* so each field is stable
// in the cycle mpu_ctrl consumes it.
module mpu_issue #(
  parameter int FIFO_DEPTH   = 4,
  parameter int MRX_IND_WTH  = 5,
  parameter int MRX_ADDR_WTH = 9,
  parameter int VR_IND_WTH   = 4,
  parameter int CMD_WTH      = 3 + 2*(2+MRX_IND_WTH+MRX_ADDR_WTH)
                               + MRX_IND_WTH + MRX_ADDR_WTH + VR_IND_WTH + 7
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [CMD_WTH-1:0]             cmd_data_i,
  output logic [1:0]                     issue_mpu__code_o,
  output logic                           issue_mpu__type_o,
  output logic                           issue_mpu0__mrs0_sl_o,
  output logic                           issue_mpu0__mrs0_sr_o,
  output logic [MRX_IND_WTH-1:0]         issue_mpu0__mrs0_index_o,
  output logic [MRX_ADDR_WTH-1:0]        issue_mpu0__mrs0_addr_o,
  output logic                           issue_mpu1__mrs0_sl_o,
  output logic                           issue_mpu1__mrs0_sr_o,
  output logic [MRX_IND_WTH-1:0]         issue_mpu1__mrs0_index_o,
  output logic [MRX_ADDR_WTH-1:0]        issue_mpu1__mrs0_addr_o,
  output logic [MRX_IND_WTH-1:0]         issue_mpu__mrs1_index_o,
  output logic [MRX_ADDR_WTH-1:0]        issue_mpu__mrs1_addr_o,
  output logic [VR_IND_WTH-1:0]          issue_mpu__vrd_index_o,
  output logic [6:0]                     issue_mpu__mac_len_o,
  output logic                           busy_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_cnt_o,
  output logic                           err_o
);

  localparam int PW   = $clog2(FIFO_DEPTH) + 1;
  localparam int AW   = PW - 1;
  localparam int BLK  = 2 + MRX_IND_WTH + MRX_ADDR_WTH;
  localparam int M0   = 3;
  localparam int M1   = M0 + BLK;
  localparam int MRS1 = M0 + 2*BLK;
  localparam int VRD  = MRS1 + MRX_IND_WTH + MRX_ADDR_WTH;
  localparam int LEN  = VRD + VR_IND_WTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MMAC = 2'd1,
    ST_MMUL = 2'd2
  } state_t;

  logic [CMD_WTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic               full, empty, push, pop;
  logic [CMD_WTH-1:0] head, head_fix;
  logic               head_legal, head_mmac;

  state_t             st, st_d;
  logic [6:0]         cnt, cnt_d;
  logic [CMD_WTH-1:0] cur_q, cur_d;
  logic               err_q, err_d;
  logic               slot;
  logic [VRD-1:0]     sel;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  // codes 1 and 3 are the only legal ones, i.e. bit 0 set
  assign head_legal = ~empty & head[0];
  assign head_mmac  = (head[1:0] == 2'b11);
  assign slot       = (st == ST_IDLE) || (st == ST_MMUL) ||
                      ((st == ST_MMAC) && (cnt == cur_q[LEN +: 7] - 7'd1));
  assign push       = cmd_valid_i & ~full;
  assign pop        = slot & ~empty;

  // descriptor storage
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_data_i;
  end

  // mirror next-state, current-op load and error flag
  always_comb begin
    st_d     = st;
    cnt_d    = cnt;
    cur_d    = cur_q;
    err_d    = err_q;
    head_fix = head;
    if (head_mmac && head[LEN +: 7] == 7'd0) head_fix[LEN +: 7] = 7'd1;
    if (slot) begin
      if (head_legal) begin
        st_d  = head_mmac ? ST_MMAC : ST_MMUL;
        cnt_d = '0;
        cur_d = head_fix;
        if (head_mmac && head[LEN +: 7] == 7'd0) err_d = 1'b1;
      end else begin
        st_d = ST_IDLE;
        if (pop) err_d = 1'b1;
      end
    end else if (st == ST_MMAC) begin
      cnt_d = cnt + 7'd1;
    end
  end

  // state, pointers and current-op registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      st     <= ST_IDLE;
      cnt    <= '0;
      cur_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      st     <= st_d;
      cnt    <= cnt_d;
      cur_q  <= cur_d;
      err_q  <= err_d;
    end
  end

  // in a slot mpu_ctrl samples the new op (or zeros = IDLE); otherwise it
  // sees the executing op so its code/type delay chains stay consistent
  always_comb begin
    sel = cur_q[VRD-1:0];
    if (slot) sel = head_legal ? head[VRD-1:0] : '0;
  end

  assign issue_mpu__code_o        = sel[1:0];
  assign issue_mpu__type_o        = sel[2];
  assign issue_mpu0__mrs0_sl_o    = sel[M0];
  assign issue_mpu0__mrs0_sr_o    = sel[M0+1];
  assign issue_mpu0__mrs0_index_o = sel[M0+2 +: MRX_IND_WTH];
  assign issue_mpu0__mrs0_addr_o  = sel[M0+2+MRX_IND_WTH +: MRX_ADDR_WTH];
  assign issue_mpu1__mrs0_sl_o    = sel[M1];
  assign issue_mpu1__mrs0_sr_o    = sel[M1+1];
  assign issue_mpu1__mrs0_index_o = sel[M1+2 +: MRX_IND_WTH];
  assign issue_mpu1__mrs0_addr_o  = sel[M1+2+MRX_IND_WTH +: MRX_ADDR_WTH];
  assign issue_mpu__mrs1_index_o  = sel[MRS1 +: MRX_IND_WTH];
  assign issue_mpu__mrs1_addr_o   = sel[MRS1+MRX_IND_WTH +: MRX_ADDR_WTH];
  assign issue_mpu__vrd_index_o   = cur_q[VRD +: VR_IND_WTH];
  assign issue_mpu__mac_len_o     = cur_q[LEN +: 7];

  assign cmd_ready_o = ~full;
  assign busy_o      = (st != ST_IDLE) | ~empty;
  assign fifo_cnt_o  = wr_ptr - rd_ptr;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mpu_issue.sv
// tb_mpu_issue: directed scenarios plus a randomized legal stream checked
// against a time-based model of when mpu_ctrl accepts each op.
module tb_mpu_issue;

  localparam int DEPTH = 4;
  localparam int CW    = 60;
  localparam int VRDL  = 49;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [CW-1:0] data = '0;
  logic        ready, busy, err;
  logic [2:0]  fcnt;
  logic [1:0]  code;
  logic        typ, m0_sl, m0_sr, m1_sl, m1_sr;
  logic [4:0]  m0_idx, m1_idx, r1_idx;
  logic [8:0]  m0_addr, m1_addr, r1_addr;
  logic [3:0]  vrd;
  logic [6:0]  mlen;
  logic [CW-1:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpu_issue #(.FIFO_DEPTH(DEPTH), .MRX_IND_WTH(5), .MRX_ADDR_WTH(9), .VR_IND_WTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(valid), .cmd_ready_o(ready), .cmd_data_i(data),
    .issue_mpu__code_o(code), .issue_mpu__type_o(typ),
    .issue_mpu0__mrs0_sl_o(m0_sl), .issue_mpu0__mrs0_sr_o(m0_sr),
    .issue_mpu0__mrs0_index_o(m0_idx), .issue_mpu0__mrs0_addr_o(m0_addr),
    .issue_mpu1__mrs0_sl_o(m1_sl), .issue_mpu1__mrs0_sr_o(m1_sr),
    .issue_mpu1__mrs0_index_o(m1_idx), .issue_mpu1__mrs0_addr_o(m1_addr),
    .issue_mpu__mrs1_index_o(r1_idx), .issue_mpu__mrs1_addr_o(r1_addr),
    .issue_mpu__vrd_index_o(vrd), .issue_mpu__mac_len_o(mlen),
    .busy_o(busy), .fifo_cnt_o(fcnt), .err_o(err)
  );

  // outputs reassembled in descriptor layout
  assign obs = {mlen, vrd, r1_addr, r1_idx, m1_addr, m1_idx, m1_sr, m1_sl,
                m0_addr, m0_idx, m0_sr, m0_sl, typ, code};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] mk(input logic [1:0] c, input logic [6:0] len,
                                       input logic [3:0] v, input logic [8:0] a0);
    return {len, v, 9'h0A5, 5'd3, 9'h1F0, 5'd7, 1'b1, 1'b0, a0, 5'd2, 1'b0, 1'b1, c[1], c};
  endfunction

  function automatic logic [CW-1:0] rnd_desc();
    logic [63:0]   r;
    logic [CW-1:0] d;
    r = {$urandom(), $urandom()};
    d = r[CW-1:0];
    d[1:0] = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd1;
    d[CW-1 -: 7] = 7'($urandom_range(1, 5));
    return d;
  endfunction

  task automatic test_reset;
    do_reset();
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %0h, expected 0", obs); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b, expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
    checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d, expected 0", fcnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b, expected 0", err); end
  endtask

  task automatic test_single_mmul;
    logic [CW-1:0] d;
    do_reset();
    d = mk(2'd1, 7'd0, 4'd5, 9'h10);
    valid = 1'b1; data = d;
    tick();
    valid = 1'b0;
    checks++; if (code !== 2'd1) begin errors++; $display("FAIL mmul_code: got %0d, expected 1", code); end
    checks++; if (m0_addr !== 9'h10) begin errors++; $display("FAIL mmul_addr: got %0h, expected 10", m0_addr); end
    checks++; if (obs[VRDL-1:0] !== d[VRDL-1:0]) begin errors++; $display("FAIL mmul_fields: got %0h, expected %0h", obs[VRDL-1:0], d[VRDL-1:0]); end
    tick();
    checks++; if (vrd !== 4'd5) begin errors++; $display("FAIL mmul_vrd: got %0d, expected 5", vrd); end
    checks++; if (code !== 2'd0) begin errors++; $display("FAIL mmul_code_back: got %0d, expected 0", code); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mmul_busy_hi: got %0b, expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mmul_busy_lo: got %0b, expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [CW-1:0] a, b;
    logic [1:0]    exp_code [5];
    exp_code = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd0};
    do_reset();
    a = mk(2'd3, 7'd3, 4'd2, 9'h33);
    b = mk(2'd1, 7'd0, 4'd9, 9'h1C4);
    valid = 1'b1; data = a;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (code !== exp_code[i]) begin errors++; $display("FAIL b2b_code[%0d]: got %0d, expected %0d", i, code, exp_code[i]); end
      if (i >= 1 && i <= 3) begin
        checks++; if (mlen !== 7'd3) begin errors++; $display("FAIL b2b_len[%0d]: got %0d, expected 3", i, mlen); end
      end
      if (i == 3) begin
        checks++; if (obs[VRDL-1:0] !== b[VRDL-1:0]) begin errors++; $display("FAIL b2b_mmul_fields: got %0h, expected %0h", obs[VRDL-1:0], b[VRDL-1:0]); end
      end
      if (i == 4) begin
        checks++; if (vrd !== 4'd9) begin errors++; $display("FAIL b2b_vrd: got %0d, expected 9", vrd); end
      end
      if (i == 0) data = b; else valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_overflow;
    int waited;
    do_reset();
    valid = 1'b1; data = mk(2'd3, 7'd100, 4'd0, 9'h0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      data = mk(2'd1, 7'd0, 4'(k), 9'(k));
      tick();
    end
    checks++; if (fcnt !== 3'd4) begin errors++; $display("FAIL ovf_cnt: got %0d, expected 4", fcnt); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %0b, expected 0", ready); end
    data = mk(2'd1, 7'd0, 4'd5, 9'd5);
    waited = 0;
    while (!ready && waited < 200) begin
      tick();
      waited++;
    end
    checks++; if (waited !== 97) begin errors++; $display("FAIL ovf_hold_cycles: got %0d, expected 97", waited); end
    checks++; if (vrd !== 4'd1) begin errors++; $display("FAIL ovf_vrd[1]: got %0d, expected 1", vrd); end
    tick();
    valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      checks++; if (vrd !== 4'(k)) begin errors++; $display("FAIL ovf_vrd[%0d]: got %0d, expected %0d", k, vrd, k); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b, expected 0", busy); end
  endtask

  task automatic test_errors;
    do_reset();
    valid = 1'b1; data = mk(2'd3, 7'd0, 4'd7, 9'h1);
    tick();
    checks++; if (code !== 2'd3) begin errors++; $display("FAIL err_l0_code: got %0d, expected 3", code); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %0b, expected 0", err); end
    data = mk(2'd2, 7'd5, 4'hB, 9'h2);
    tick();
    checks++; if (obs[VRDL-1:0] !== '0) begin errors++; $display("FAIL err_drop_fields: got %0h, expected 0", obs[VRDL-1:0]); end
    checks++; if (mlen !== 7'd1) begin errors++; $display("FAIL err_coerced_len: got %0d, expected 1", mlen); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b, expected 1", err); end
    data = mk(2'd1, 7'd0, 4'd9, 9'h3);
    tick();
    valid = 1'b0;
    checks++; if (code !== 2'd1) begin errors++; $display("FAIL err_next_code: got %0d, expected 1", code); end
    tick();
    checks++; if (vrd !== 4'd9) begin errors++; $display("FAIL err_next_vrd: got %0d, expected 9", vrd); end
    tick(); tick(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b, expected 1", err); end
    checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL err_fifo_empty: got %0d, expected 0", fcnt); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    valid = 1'b1; data = mk(2'd3, 7'd8, 4'd4, 9'h4);
    tick();
    data = mk(2'd1, 7'd0, 4'd1, 9'h5);
    tick();
    data = mk(2'd1, 7'd0, 4'd2, 9'h6);
    tick();
    valid = 1'b0;
    checks++; if (fcnt !== 3'd2) begin errors++; $display("FAIL rmid_queued: got %0d, expected 2", fcnt); end
    checks++; if (code !== 2'd3) begin errors++; $display("FAIL rmid_running: got %0d, expected 3", code); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (obs !== '0) begin errors++; $display("FAIL rmid_outputs: got %0h, expected 0", obs); end
    checks++; if (fcnt !== 3'd0) begin errors++; $display("FAIL rmid_cnt: got %0d, expected 0", fcnt); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %0b, expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b, expected 0", busy); end
  endtask

  // Model: each legal op occupies mpu_ctrl for L cycles (MMAC) or 1 (MMUL);
  // the next acceptance opportunity is the cycle that occupancy ends.
  task automatic test_random;
    logic [CW-1:0] mq [$];
    logic [CW-1:0] cur, h, exp;
    logic [6:0]    hl;
    int t, free_at, n_push, n_issue;
    bit active, slot, acc, fresh;
    localparam int N = 400;
    do_reset();
    mq.delete();
    cur = '0; t = 0; free_at = 0; active = 0; n_push = 0; n_issue = 0;
    fresh = 1;
    for (int i = 0; i < N + 60; i++) begin
      if (i >= N) valid = 1'b0;
      else if (fresh) begin
        valid = ($urandom_range(0, 9) < 6);
        data  = rnd_desc();
      end
      slot = (t >= free_at);
      exp = cur;
      if (slot) begin
        exp[VRDL-1:0] = '0;
        if (mq.size() > 0) begin
          h = mq[0];
          if (h[0]) exp[VRDL-1:0] = h[VRDL-1:0];
        end
      end
      checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_outputs@%0d: got %0h, expected %0h", t, obs, exp); end
      checks++; if (ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d: got %0b, expected %0b", t, ready, mq.size() < DEPTH); end
      checks++; if (int'(fcnt) !== mq.size()) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d, expected %0d", t, fcnt, mq.size()); end
      checks++; if (busy !== (active || mq.size() > 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %0b, expected %0b", t, busy, active || mq.size() > 0); end
      acc = valid && (mq.size() < DEPTH);
      if (slot) begin
        free_at = t + 1;
        active = 0;
        if (mq.size() > 0) begin
          h = mq.pop_front();
          if (h[0]) begin
            hl = h[CW-1 -: 7];
            if (h[1:0] == 2'd3 && hl == 7'd0) hl = 7'd1;
            h[CW-1 -: 7] = hl;
            cur = h;
            active = 1;
            n_issue++;
            if (h[1:0] == 2'd3) free_at = t + int'(hl);
          end
        end
      end
      if (acc) begin
        mq.push_back(data);
        n_push++;
      end
      fresh = !valid || acc;
      tick();
      t++;
    end
    checks++; if (n_issue !== n_push) begin errors++; $display("FAIL rnd_consumed: got %0d, expected %0d", n_issue, n_push); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %0b, expected 0", err); end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_mmul();
    test_back_to_back();
    test_overflow();
    test_errors();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
